fir_tap_mac_pipe: RTL and testbench

Parametrised, pipelined N-tap signed FIR filter and the successor to the fixed 4-tap moving-sum adder. It takes a valid-qualified sample stream, keeps a TAPS-deep delay line, multiplies each tap by a programmable signed coefficient, and reduces the products with a registered binary adder tree. Coefficients reset to +1, so after reset the block acts as a TAPS-wide moving sum. It sits between the sample source and downstream decimation/output logic.

---
 rtl/fir_tap_mac_pipe.sv | 133 +++++++++++++
 tb/tb_fir_tap_mac_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_mac_pipe.sv
// Pipelined N-tap signed FIR: valid-qualified delay line, one multiply stage per tap,
// and a registered binary adder tree. Coefficients reset to +1, which gives a moving sum.
module fir_tap_mac_pipe #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int LOG2T  = $clog2(TAPS),
    parameter int OUT_W  = DATA_W + COEF_W + LOG2T
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    input  logic              coef_we,
    input  logic [LOG2T-1:0]  coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [DATA_W-1:0] tap_reg  [TAPS];
    logic signed [COEF_W-1:0] coef_reg [TAPS];
    logic signed [PROD_W-1:0] prod_reg [TAPS];
    logic                     tap_vld_reg;
    logic                     prod_vld_reg;
    logic signed [OUT_W-1:0]  out_data_reg;
    logic                     out_valid_reg;

    // Coefficients survive clear; only reset restores the +1 moving-sum default.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < TAPS; j++) begin
                coef_reg[j] <= COEF_W'(1);
            end
        end else if (coef_we) begin
            coef_reg[coef_addr] <= coef_wdata;
        end
    end

    // The delay line advances only on accepted samples, so input gaps leave history intact.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            tap_vld_reg <= 1'b0;
            for (int j = 0; j < TAPS; j++) begin
                tap_reg[j] <= '0;
            end
        end else begin
            tap_vld_reg <= in_valid;
            if (in_valid) begin
                tap_reg[0] <= in_data;
                for (int j = 1; j < TAPS; j++) begin
                    tap_reg[j] <= tap_reg[j-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prod_vld_reg <= 1'b0;
            for (int j = 0; j < TAPS; j++) begin
                prod_reg[j] <= '0;
            end
        end else begin
            prod_vld_reg <= tap_vld_reg;
            for (int j = 0; j < TAPS; j++) begin
                prod_reg[j] <= PROD_W'(tap_reg[j]) * PROD_W'(coef_reg[j]);
            end
        end
    end

    // Tree level gi holds TAPS>>gi sums, each one bit wider than its inputs.
    genvar gi, gj;
    generate
        for (gi = 1; gi <= LOG2T; gi++) begin : g_lvl
            localparam int W = PROD_W + gi;
            localparam int N = TAPS >> gi;

            logic signed [W-2:0] src [2*N];
            logic                vld_src;
            logic signed [W-1:0] sum_reg [N];
            logic                vld_reg;

            if (gi == 1) begin : g_first
                for (gj = 0; gj < 2*N; gj++) begin : g_src
                    assign src[gj] = prod_reg[gj];
                end
                assign vld_src = prod_vld_reg;
            end else begin : g_next
                for (gj = 0; gj < 2*N; gj++) begin : g_src
                    assign src[gj] = g_lvl[gi-1].sum_reg[gj];
                end
                assign vld_src = g_lvl[gi-1].vld_reg;
            end

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    vld_reg <= 1'b0;
                    for (int j = 0; j < N; j++) begin
                        sum_reg[j] <= '0;
                    end
                end else begin
                    vld_reg <= vld_src;
                    for (int j = 0; j < N; j++) begin
                        sum_reg[j] <= W'(src[2*j]) + W'(src[2*j+1]);
                    end
                end
            end
        end
    endgenerate

    // The output register only captures results that carry a valid bit; otherwise it holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (clear) begin
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= g_lvl[LOG2T].vld_reg;
            if (g_lvl[LOG2T].vld_reg) begin
                out_data_reg <= g_lvl[LOG2T].sum_reg[0];
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_fir_tap_mac_pipe.sv
// Directed bench for fir_tap_mac_pipe: stimulus pushes hand-computed results with their
// due cycle into a scoreboard; a negedge monitor pops and checks every output pulse.
module tb_fir_tap_mac_pipe;

    localparam int DATA_W = 16;
    localparam int COEF_W = 8;
    localparam int TAPS   = 8;
    localparam int LOG2T  = 3;
    localparam int OUT_W  = 27;
    // Drive happens one cycle before the accepting edge; result is 5 edges after accept.
    localparam int LAT    = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              clear;
    logic              coef_we;
    logic [LOG2T-1:0]  coef_addr;
    logic [COEF_W-1:0] coef_wdata;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;

    typedef struct {
        logic [OUT_W-1:0] val;
        int               cyc;
    } exp_t;

    exp_t             sb_q[$];
    int               cyc     = 0;
    int               checks  = 0;
    int               errors  = 0;
    int               n_out   = 0;
    bit               rst_at_edge = 1'b0;
    bit               started = 1'b0;
    logic [OUT_W-1:0] hold_exp = '0;

    fir_tap_mac_pipe #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .TAPS  (TAPS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_at_edge = reset;
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_at_edge) begin
            started = 1'b1;
            checks++;
            if (out_valid !== 1'b0 || out_data !== '0) begin
                errors++;
                $display("FAIL reset_state: out_valid=%b out_data=%0d, required 0/0", out_valid, $signed(out_data));
            end
            hold_exp = '0;
        end else if (started) begin
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: cyc=%0d out_data=%0d, required no output", cyc, $signed(out_data));
                end else begin
                    e = sb_q.pop_front();
                    n_out++;
                    checks += 2;
                    $display("out #%0d cyc=%0d data=%0d expected=%0d due_cyc=%0d",
                             n_out, cyc, $signed(out_data), $signed(e.val), e.cyc);
                    if (out_data !== e.val) begin
                        errors++;
                        $display("FAIL out_data #%0d: got %0d, required %0d", n_out, $signed(out_data), $signed(e.val));
                    end
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL latency #%0d: arrived cyc %0d, required cyc %0d", n_out, cyc, e.cyc);
                    end
                    hold_exp = e.val;
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0 || out_data !== hold_exp) begin
                    errors++;
                    $display("FAIL hold cyc=%0d: out_valid=%b out_data=%0d, required 0/%0d",
                             cyc, out_valid, $signed(out_data), $signed(hold_exp));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input int exp_val, input bit chk);
        exp_t e;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        if (chk) begin
            e.val = OUT_W'(exp_val);
            e.cyc = cyc + LAT;
            sb_q.push_back(e);
        end
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we    = 1'b1;
        coef_addr  = LOG2T'(addr);
        coef_wdata = COEF_W'(val);
        step();
        coef_we = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d, required 0", sb_q.size());
            sb_q.delete();
        end
        repeat (3) step();
    endtask

    initial begin
        int boxcar[10] = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 52};
        reset = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        step();
        step();
        reset = 1'b0;
        step();

        // 1: boxcar after reset
        for (int i = 0; i < 10; i++) send(i + 1, boxcar[i], 1'b1);
        drain();

        // 2: same stream with gaps
        do_clear();
        for (int i = 0; i < 10; i++) begin
            send(i + 1, boxcar[i], 1'b1);
            step();
        end
        drain();

        // 3: y = 2*x[n] - x[n-1]
        write_coef(0, 2);
        write_coef(1, -1);
        for (int i = 2; i < TAPS; i++) write_coef(i, 0);
        do_clear();
        send(5, 10, 1'b1);
        send(7, 9, 1'b1);
        send(4, 1, 1'b1);
        drain();

        // 4: extremes
        for (int i = 0; i < TAPS; i++) write_coef(i, -128);
        do_clear();
        for (int i = 0; i < TAPS; i++) send(-32768, 4194304 * (i + 1), 1'b1);
        drain();

        // 5: clear mid-stream, clear with in_valid and coef_we in the same cycle
        write_coef(0, 3);
        for (int i = 1; i < TAPS; i++) write_coef(i, 1);
        do_clear();
        send(1, 3, 1'b1);
        for (int i = 2; i <= 6; i++) send(i, 0, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_data = DATA_W'(99);
        coef_we = 1'b1; coef_addr = '0; coef_wdata = COEF_W'(1);
        step();
        clear = 1'b0; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
        send(10, 10, 1'b1);
        send(10, 20, 1'b1);
        drain();

        // 6: reset while samples are in flight
        write_coef(0, 5);
        send(7, 0, 1'b0);
        send(7, 0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (8) step();
        send(3, 3, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
